// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces a raw button, producing a clean level,
// one-cycle rise/fall pulses and a wrapping count of accepted presses.
module btn_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic [7:0] press_count
);
    typedef enum logic [1:0] {ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_s0, r_s1;
    logic             r_level, w_level_nxt;
    logic             r_rise, w_rise_nxt;
    logic             r_fall, w_fall_nxt;
    logic [7:0]       r_press, w_press_nxt;
    logic             w_sync;
    logic             w_done;

    assign w_sync = r_s1;
    assign w_done = (r_cnt == CNT_W'(STABLE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_press <= '0;
        end else begin
            r_s0    <= btn_in;
            r_s1    <= r_s0;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_press <= w_press_nxt;
        end
    end

    // Each WAIT state either falls back on a mismatching sample or counts up to acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_press_nxt = r_press;
        case (r_state)
            ST_LOW: begin
                if (w_sync) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (w_done) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_press_nxt = r_press + 8'd1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                if (w_sync) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else if (w_done) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    assign level       = r_level;
    assign rise        = r_rise;
    assign fall        = r_fall;
    assign press_count = r_press;
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: randomized and directed stimulus against a run-length reference model.
module tb_btn_debounce;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_in = 1'b0;
    logic       level, rise, fall;
    logic [7:0] press_count;

    int total = 0;
    int bad = 0;

    bit q[$];
    int run;
    bit m_level, m_rise, m_fall;
    int m_press;

    btn_debounce #(.STABLE_CYCLES(S), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .level(level), .rise(rise), .fall(fall), .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        run = 0;
        m_level = 0;
        m_rise = 0;
        m_fall = 0;
        m_press = 0;
    endtask

    // A new level is accepted once S+1 consecutive synchronized samples disagree with it.
    task automatic model_edge(input bit b);
        bit sync;
        sync = (q.size() >= 2) ? q[q.size()-2] : 1'b0;
        q.push_back(b);
        if (q.size() > 4) void'(q.pop_front());
        m_rise = 0;
        m_fall = 0;
        run = (sync != m_level) ? run + 1 : 0;
        if (run == S + 1) begin
            m_level = sync;
            run = 0;
            if (sync) begin
                m_rise = 1;
                m_press = (m_press + 1) % 256;
            end else begin
                m_fall = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_level"}, level, m_level);
        chk({tag, "_rise"}, rise, m_rise);
        chk({tag, "_fall"}, fall, m_fall);
        chk({tag, "_cnt"}, press_count, m_press);
        chk({tag, "_excl"}, rise & fall, 0);
    endtask

    task automatic step(input bit b, input string tag);
        btn_in = b;
        @(posedge clk);
        model_edge(b);
        #1 check_all(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        chk("rst_cnt", press_count, 0);
        @(negedge clk);
        model_reset();
        rst_n = 1;
    endtask

    initial begin
        int rise_at, rise_n, fall_at;
        bit b;
        model_reset();
        btn_in = 0;
        repeat (2) @(posedge clk);
        do_reset();

        rise_at = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1, "press");
            if (rise && rise_at == 0) rise_at = i;
        end
        chk("press_edge", rise_at, 7);
        chk("press_total", press_count, 1);

        fall_at = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, "release");
            if (fall && fall_at == 0) fall_at = i;
        end
        chk("release_edge", fall_at, 7);
        chk("release_cnt", press_count, 1);

        do_reset();
        for (int i = 0; i < 3; i++) step(1, "glitch");
        for (int i = 0; i < 12; i++) step(0, "glitch");
        chk("glitch_cnt", press_count, 0);

        rise_n = 0;
        rise_at = 0;
        step(1, "bounce"); step(0, "bounce"); step(1, "bounce"); step(0, "bounce");
        for (int i = 1; i <= 15; i++) begin
            step(1, "bounce");
            if (rise) begin
                rise_n++;
                rise_at = i;
            end
        end
        chk("bounce_rises", rise_n, 1);
        chk("bounce_edge", rise_at, 7);
        chk("bounce_cnt", press_count, 1);

        do_reset();
        for (int p = 0; p < 256; p++) begin
            for (int i = $urandom_range(8, 11); i > 0; i--) step(1, "wrap");
            for (int i = $urandom_range(8, 11); i > 0; i--) step(0, "wrap");
        end
        chk("wrap_zero", press_count, 0);
        for (int i = 0; i < 9; i++) step(1, "wrap257");
        chk("wrap_one", press_count, 1);
        for (int i = 0; i < 9; i++) step(0, "wrap257");

        for (int i = 0; i < 5; i++) step(1, "midq");
        rst_n = 0;
        #1;
        chk("midq_level", level, 0);
        chk("midq_rise", rise, 0);
        chk("midq_fall", fall, 0);
        chk("midq_cnt", press_count, 0);
        @(negedge clk);
        model_reset();
        rst_n = 1;
        rise_at = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1, "relhi");
            if (rise && rise_at == 0) rise_at = i;
        end
        chk("relhi_edge", rise_at, 7);
        chk("relhi_cnt", press_count, 1);

        b = 0;
        for (int r = 0; r < 200; r++) begin
            b = ~b;
            for (int i = $urandom_range(1, 8); i > 0; i--) step(b, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream conditioning stage for the lab flip-flop stage. It takes a raw, asynchronous, bouncy push-button/switch input and delivers a clean, synchronous level plus single-cycle edge pulses.
- `level` drives the `d` input of the downstream dff; `rise`/`fall`/`press_count` are available to neighbouring logic.
- Contains a 2-flop synchronizer, a 4-state debounce FSM with a stability counter, edge-pulse generation and a wrapping press counter.

Parameters:
- STABLE_CYCLES, 4: number of consecutive synchronized samples (beyond the first) that must match before a new level is accepted; legal range 2..65535.
- CNT_W, 16: width of the stability counter; must satisfy 2^CNT_W >= STABLE_CYCLES.

Ports:
- clk  input  1  single system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- btn_in  input  1  raw button/switch input, asynchronous to clk, may bounce
- level  output  1  debounced, registered level; feeds downstream dff d
- rise  output  1  one-cycle pulse when level goes 0->1
- fall  output  1  one-cycle pulse when level goes 1->0
- press_count  output  8  count of accepted rises, wraps 255->0

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - sync flops s0=s1=0, state=STABLE_LOW, cnt=0
  - level=0, rise=0, fall=0, press_count=0
  - All outputs are registered; no combinational path from btn_in to any output.
- Synchronizer: s0<=btn_in, s1<=s0 each edge; btn_sync=s1. Only btn_sync is used by the FSM.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
  - STABLE_LOW: if btn_sync=1 -> WAIT_HIGH, cnt<=0; else stay.
  - WAIT_HIGH:
    - btn_sync=0 -> STABLE_LOW, cnt<=0, no pulse (glitch rejected).
    - btn_sync=1 and cnt==STABLE_CYCLES-1 -> STABLE_HIGH, level<=1, rise<=1, press_count<=press_count+1 (mod 256).
    - btn_sync=1 otherwise -> cnt<=cnt+1.
  - STABLE_HIGH / WAIT_LOW: mirror of the above with polarity inverted. Acceptance sets level<=0 and fall<=1; press_count is unchanged.
- rise and fall are high for exactly one cycle and are never asserted together; both are 0 in every cycle that is not an acceptance edge.
- Latency: btn_in stably changed before edge 1 -> level changes after edge STABLE_CYCLES+3. This is 7 edges at default, with rise/fall valid in that same cycle.
- Minimum accepted pulse: btn_sync must hold the new value for STABLE_CYCLES+1 consecutive samples. Shorter pulses produce no level change and no pulse.
- Bounce during WAIT restarts qualification from the stable state; cnt is never carried over.
- Reset released with btn_in held high: treated as a fresh press. level rises STABLE_CYCLES+3 edges after the first edge following release, rise pulses, and press_count=1.
- Reset asserted mid-qualification or mid-pulse: everything clears immediately. A pending rise/fall is discarded and never re-emitted.
- press_count wraps 255->0 with no flag.
- The stability counter never exceeds STABLE_CYCLES-1.

Test Plan (STABLE_CYCLES=4):
- Clean press: rst_n released, btn_in 0->1 held 20 cycles -> level=1 and rise=1 exactly 7 edges after the change; fall=0; press_count=1; rise back to 0 on the next edge.
- Glitch: btn_in high for 3 cycles then low -> level stays 0, rise never asserts, press_count=0.
- Bounce: btn_in toggles 1,0,1,0,1 (1 cycle each) then holds 1 -> exactly one rise, occurring 7 edges after the final 0->1; press_count=1.
- Release: from level=1, btn_in 1->0 held -> fall=1 for one cycle 7 edges later; level=0; press_count unchanged.
- Wrap: 256 clean press/release pairs -> press_count returns to 0; 257th press -> press_count=1.
- Reset mid-operation: assert rst_n=0 in WAIT_HIGH (cnt=2) -> level, rise, fall and press_count read 0 immediately. Release with btn_in held 1 -> rise 7 edges after release, press_count=1.
